alu_cmd_seq: RTL

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of a multi-unit ALU: registers operands/opcode, waits for the
// selected unit's valid flag (or a timeout) and returns one captured response per command.
module alu_cmd_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LAT     = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_fun,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       ALU_FUN,
    input  logic [WIDTH-1:0] Arith_OUT,
    input  logic [WIDTH-1:0] Logic_OUT,
    input  logic [WIDTH-1:0] CMP_OUT,
    input  logic [WIDTH-1:0] Shift_OUT,
    input  logic             Carry_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [7:0]       op_count
);

    localparam int unsigned   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
    // A latency beyond the timeout is clamped so the counter compare stays in range.
    localparam logic [CW-1:0] LAT_C = (LAT > TIMEOUT) ? TO_C : CW'(LAT);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [WIDTH-1:0] sel_out;
    logic            sel_flag;
    logic            sel_arith;

    always_comb begin
        sel_out  = Arith_OUT;
        sel_flag = Arith_Flag;
        case (ALU_FUN[3:2])
            2'b00: begin
                sel_out  = Arith_OUT;
                sel_flag = Arith_Flag;
            end
            2'b01: begin
                sel_out  = Logic_OUT;
                sel_flag = Logic_Flag;
            end
            2'b10: begin
                sel_out  = CMP_OUT;
                sel_flag = CMP_Flag;
            end
            default: begin
                sel_out  = Shift_OUT;
                sel_flag = Shift_Flag;
            end
        endcase
    end

    assign sel_arith = (ALU_FUN[3:2] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cmd_ready <= 1'b0;
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    // cmd_ready is registered, so it first rises one edge after reset release.
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        A         <= cmd_a;
                        B         <= cmd_b;
                        ALU_FUN   <= cmd_fun;
                        wait_cnt  <= '0;
                        cmd_ready <= 1'b0;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt != TO_C) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                    if ((wait_cnt >= LAT_C) && sel_flag) begin
                        rsp_data  <= sel_out;
                        rsp_carry <= sel_arith ? Carry_OUT : 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else if (wait_cnt == TO_C) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        op_count  <= op_count + 8'd1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule
